sync_debounce: RTL and testbench
================================

Name: sync_debounce

Overview:
Input-conditioning stage that drives the D-flip-flop storage elements from raw asynchronous sources such as switches or external pins. The raw input passes through a parameterisable chain of D flip-flops for synchronisation. A counter-based qualifier then rejects glitches shorter than a programmable window. Outputs are a clean registered level plus single-cycle rise and fall pulses for downstream sequential logic.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops; legal range 2 or more.
DEBOUNCE_CYCLES, 16, consecutive clocks a new level must persist before it is accepted; legal range 1 or more.
RESET_LEVEL, 0, value loaded into synchroniser flops and q_out on reset.
CNT_W, 8, width of evt_count; used only when SYNC_DEBOUNCE_EVT_CNT_EN is defined.

Ports:
clk  input  1  single system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
d_in  input  1  raw asynchronous input
q_out  output  1  debounced, registered level
rise_pulse  output  1  one-cycle pulse on the edge where q_out goes 0->1
fall_pulse  output  1  one-cycle pulse on the edge where q_out goes 1->0
busy  output  1  high while a candidate level change is being qualified

Behaviour:
- Reset (rst high at a clk edge):
  - all synchroniser flops = RESET_LEVEL; q_out = RESET_LEVEL
  - rise_pulse = 0, fall_pulse = 0, busy = 0, qualify counter = 0
  - rst dominates every other event.
- Synchroniser: stage 1 samples d_in, each later stage samples the previous one; sync_q is the last stage.
- Qualify counter: width clog2(DEBOUNCE_CYCLES+1).
- State machine:
  - STABLE: if sync_q != q_out, go to QUALIFY with cnt = 1. Exception: when DEBOUNCE_CYCLES = 1, update q_out immediately and stay in STABLE.
  - QUALIFY: if sync_q == q_out, go to STABLE with cnt = 0 (glitch rejected, no pulse). Otherwise cnt increments.
  - QUALIFY completion: on the edge where the mismatch count reaches DEBOUNCE_CYCLES, q_out <= sync_q, the matching pulse is asserted, cnt = 0, state = STABLE.
- busy = (state == QUALIFY). busy is high for DEBOUNCE_CYCLES-1 cycles per accepted change and never high when DEBOUNCE_CYCLES = 1.
- Latency: a new d_in level held stable, first sampled at edge E1, appears on q_out after edge E(SYNC_STAGES+DEBOUNCE_CYCLES). With defaults this is edge 18.
- Pulses:
  - registered; each high for exactly one cycle, coincident with the q_out change
  - rise_pulse and fall_pulse are never both high
  - no pulse without a q_out change
- Glitch rule: any mismatch run shorter than DEBOUNCE_CYCLES consecutive edges leaves q_out unchanged and clears cnt.
- Back-to-back changes: the opposite change may begin qualifying on the edge after an update. Minimum spacing between opposite pulses is DEBOUNCE_CYCLES edges.
- Reset mid-qualification aborts with no pulse. After release, re-qualification starts from the reset state, with full latency counted from the first non-reset edge.
- No combinational path from d_in to any output.

Optional Feature:
Macro SYNC_DEBOUNCE_EVT_CNT_EN.
- Defined:
  - adds output port evt_count, CNT_W bits wide
  - evt_count is reset to 0 by rst
  - increments on the same edge rise_pulse is asserted
  - saturates at all-ones, with no wrap
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

Test Plan:
1. Reset hold: rst=1 for 3 cycles, d_in=1, RESET_LEVEL=0 -> q_out=0, rise_pulse=0, fall_pulse=0, busy=0 throughout.
2. Clean rise, defaults: d_in 0->1 held -> q_out=1 after edge 18; rise_pulse high that cycle only; busy high for 15 cycles immediately before.
3. Glitch rejection: d_in high for 10 cycles, then low -> q_out stays 0, no pulse, busy falls to 0 once sync_q returns to 0.
4. Clean fall: from q_out=1, d_in 1->0 held -> q_out=0 after edge 18; fall_pulse for one cycle; rise_pulse stays 0.
5. Reset mid-qualify: d_in rises, rst pulsed for 1 cycle at edge 10, d_in held 1 -> no pulse before reset; q_out=1 after the 18th edge following rst deassertion.
6. Macro on, CNT_W=2: 5 clean rise/fall pairs -> evt_count reads 1, 2, 3, 3, 3 after each rise; rst returns it to 0.

Source files
------------

// File: rtl/sync_debounce.sv
// Synchroniser plus counter-based debounce qualifier with edge pulses.
// Optional saturating rise-event counter: SYNC_DEBOUNCE_EVT_CNT_EN.
module sync_debounce #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RESET_LEVEL     = 1'b0
`ifdef SYNC_DEBOUNCE_EVT_CNT_EN
  ,
  parameter int   CNT_W           = 8
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic q_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
`ifdef SYNC_DEBOUNCE_EVT_CNT_EN
  ,
  output logic [CNT_W-1:0] evt_count
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    STABLE,
    QUALIFY
  } state_t;

  state_t state;
  state_t state_nx;

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_q;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_nx;
  logic                   q_nx;
  logic                   rise_nx;
  logic                   fall_nx;

  assign sync_q = sync[SYNC_STAGES-1];
  assign busy   = (state == QUALIFY);

  // Shift the raw input through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d_in};
    end
  end

  // Qualifier state, counter, output level and pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= STABLE;
      cnt        <= '0;
      q_out      <= RESET_LEVEL;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      q_out      <= q_nx;
      rise_pulse <= rise_nx;
      fall_pulse <= fall_nx;
    end
  end

  // Count consecutive mismatches; accept the new level on the last one.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    q_nx     = q_out;
    rise_nx  = 1'b0;
    fall_nx  = 1'b0;
    unique case (state)
      STABLE: begin
        if (sync_q != q_out) begin
          if (DEBOUNCE_CYCLES == 1) begin
            q_nx    = sync_q;
            rise_nx = sync_q;
            fall_nx = ~sync_q;
          end else begin
            state_nx = QUALIFY;
            cnt_nx   = CW'(1);
          end
        end
      end
      QUALIFY: begin
        if (sync_q == q_out) begin
          state_nx = STABLE;
          cnt_nx   = '0;
        end else if (cnt == LAST) begin
          state_nx = STABLE;
          cnt_nx   = '0;
          q_nx     = sync_q;
          rise_nx  = sync_q;
          fall_nx  = ~sync_q;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
    endcase
  end

`ifdef SYNC_DEBOUNCE_EVT_CNT_EN
  // Saturating count of accepted rising edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_count <= '0;
    end else if (rise_nx && (evt_count != '1)) begin
      evt_count <= evt_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// Directed scoreboard bench for sync_debounce (default parameters).
// Expectations are queued at drive time and popped after each edge.
module tb_sync_debounce;

  logic clk;
  logic rst;
  logic d_in;
  logic q_out;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;
`ifdef SYNC_DEBOUNCE_EVT_CNT_EN
  logic [1:0] evt_count;
  logic [1:0] ev;
`endif

  int errors;
  int checks;
  logic mq;

  typedef struct {
    string tag;
    logic  q;
    logic  r;
    logic  f;
    logic  b;
    logic [1:0] evt;
  } exp_t;

  exp_t sbq[$];

`ifdef SYNC_DEBOUNCE_EVT_CNT_EN
  sync_debounce #(.CNT_W(2)) dut (
`else
  sync_debounce dut (
`endif
    .clk        (clk),
    .rst        (rst),
    .d_in       (d_in),
    .q_out      (q_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .busy       (busy)
`ifdef SYNC_DEBOUNCE_EVT_CNT_EN
    ,
    .evt_count  (evt_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input string sig,
                     input logic [1:0] got,
                     input logic [1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s %s got=%0b expected=%0b",
             tag, sig, got, exp);
    end
  endtask

  task automatic tick(input string tag,
                      input logic d,
                      input logic r,
                      input logic eq,
                      input logic er,
                      input logic ef,
                      input logic eb);
    exp_t e;
    e.tag = tag;
    e.q   = eq;
    e.r   = er;
    e.f   = ef;
    e.b   = eb;
    e.evt = 2'b00;
`ifdef SYNC_DEBOUNCE_EVT_CNT_EN
    if (r) ev = 2'b00;
    else if (er && ev != 2'b11) ev = ev + 2'b01;
    e.evt = ev;
`endif
    d_in = d;
    rst  = r;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk(e.tag, "q_out", {1'b0, q_out}, {1'b0, e.q});
    chk(e.tag, "rise", {1'b0, rise_pulse}, {1'b0, e.r});
    chk(e.tag, "fall", {1'b0, fall_pulse}, {1'b0, e.f});
    chk(e.tag, "busy", {1'b0, busy}, {1'b0, e.b});
`ifdef SYNC_DEBOUNCE_EVT_CNT_EN
    chk(e.tag, "evt_count", evt_count, e.evt);
`endif
  endtask

  // Full accepted change: 2 sync edges, 15 busy edges, update on edge 18.
  task automatic seg(input string tag, input logic d);
    logic qo;
    qo = mq;
    for (int i = 1; i <= 18; i++) begin
      if (i <= 2)       tick(tag, d, 1'b0, qo, 1'b0, 1'b0, 1'b0);
      else if (i <= 17) tick(tag, d, 1'b0, qo, 1'b0, 1'b0, 1'b1);
      else              tick(tag, d, 1'b0, d, d, ~d, 1'b0);
    end
    mq = d;
  endtask

  task automatic hold(input string tag, input logic d, input int n);
    for (int i = 0; i < n; i++)
      tick(tag, d, 1'b0, mq, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    mq     = 1'b0;
    rst    = 1'b1;
    d_in   = 1'b1;
`ifdef SYNC_DEBOUNCE_EVT_CNT_EN
    ev     = 2'b00;
`endif

    for (int i = 0; i < 3; i++)
      tick("reset_hold", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    seg("clean_rise", 1'b1);
    hold("rise_hold", 1'b1, 2);

    seg("clean_fall", 1'b0);
    hold("fall_hold", 1'b0, 2);

    for (int i = 1; i <= 10; i++)
      tick("glitch_hi", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, i > 2);
    tick("glitch_lo", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick("glitch_lo", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    hold("glitch_idle", 1'b0, 5);

    for (int i = 1; i <= 9; i++)
      tick("mid_qual", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, i > 2);
    tick("mid_rst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    mq = 1'b0;
    seg("post_rst_rise", 1'b1);
    hold("post_rst_hold", 1'b1, 2);

    tick("pre_pairs_rst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    mq = 1'b0;
    for (int p = 0; p < 5; p++) begin
      seg("pair_rise", 1'b1);
      seg("pair_fall", 1'b0);
    end
    tick("final_rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    hold("final_idle", 1'b0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
